// File: rtl/shift_seq_pkg.sv
// Shared types and the pattern step function for the LED shift sequencer.
// Optional feature macro: SHIFT_SEQ_PAUSE_EN (see shift_sequencer.sv).
package shift_seq_pkg;

    localparam int unsigned LED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef logic [1:0]       amt_t;
    typedef logic [LED_W-1:0] led_t;

    // Pattern is doubled (rotate) or padded with the fill bit (shift) so a
    // single shift of the 16-bit word covers both cases.
    function automatic led_t step(input led_t pat, input amt_t amt,
                                  input logic dir, input logic rot,
                                  input logic fill);
        logic [2*LED_W-1:0] ext;
        led_t               res;
        if (dir == DIR_LEFT) begin
            ext = rot ? {pat, pat} : {pat, {LED_W{fill}}};
            ext = ext << amt;
            res = ext[2*LED_W-1:LED_W];
        end else begin
            ext = rot ? {pat, pat} : {{LED_W{fill}}, pat};
            ext = ext >> amt;
            res = ext[LED_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Command / status bundle of the shift sequencer.
// The pause input exists only when SHIFT_SEQ_PAUSE_EN is defined.
interface shift_seq_if
    import shift_seq_pkg::*;
#(
    parameter int unsigned STEP_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    led_t              cmd_data;
    amt_t              cmd_amt;
    logic              cmd_dir;
    logic              cmd_rot;
    logic              cmd_fill;
    logic [STEP_W-1:0] cmd_steps;
    logic              abort;
    led_t              led;
    logic              busy;
    logic              done;
`ifdef SHIFT_SEQ_PAUSE_EN
    logic              pause;
`endif

    modport master (
`ifdef SHIFT_SEQ_PAUSE_EN
        output pause,
`endif
        output cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_rot, cmd_fill,
        output cmd_steps, abort,
        input  cmd_ready, led, busy, done
    );

    modport slave (
`ifdef SHIFT_SEQ_PAUSE_EN
        input  pause,
`endif
        input  cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_rot, cmd_fill,
        input  cmd_steps, abort,
        output cmd_ready, led, busy, done
    );

endinterface

// File: rtl/shift_seq_tick.sv
// Step-rate prescaler: counts TICK_DIV enabled cycles and raises a registered
// one-cycle tick on the cycle after the wrap; clear forces count and tick to 0.
module shift_seq_tick #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = tick_q;
        if (clr_i) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                tick_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/shift_sequencer.sv
// LED pattern sequencer: accepts a command, then rotates/shifts the pattern
// once per TICK_DIV cycles for cmd_steps steps. SHIFT_SEQ_PAUSE_EN adds a pause input.
//
//   state   | meaning
//   IDLE    | waiting for a command, cmd_ready high
//   RUN     | executing steps, busy high
//   DONE    | one-cycle completion pulse on done
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000,
    parameter int unsigned STEP_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_seq_if.slave  bus
);

    state_e            state_q, state_d;
    led_t              led_q, led_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    amt_t              amt_q, amt_d;
    logic              dir_q, dir_d;
    logic              rot_q, rot_d;
    logic              fill_q, fill_d;
    logic              pause_w;
    logic              run_en;
    logic              tick;

`ifdef SHIFT_SEQ_PAUSE_EN
    assign pause_w = bus.pause;
`else
    assign pause_w = 1'b0;
`endif

    assign run_en = (state_q == ST_RUN) && !pause_w;

    shift_seq_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_RUN),
        .en_i   (run_en),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        steps_d = steps_q;
        amt_d   = amt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    led_d   = bus.cmd_data;
                    steps_d = bus.cmd_steps;
                    amt_d   = bus.cmd_amt;
                    dir_d   = bus.cmd_dir;
                    rot_d   = bus.cmd_rot;
                    fill_d  = bus.cmd_fill;
                    state_d = (bus.cmd_steps == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a coinciding step so the pattern is left untouched.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (tick && run_en) begin
                    led_d   = step(led_q, amt_q, dir_q, rot_q, fill_q);
                    steps_d = steps_q - STEP_W'(1);
                    if (steps_q == STEP_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            led_q   <= '0;
            steps_q <= '0;
            amt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            steps_q <= steps_d;
            amt_q   <= amt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            fill_q  <= fill_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.led       = led_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with TICK_DIV = 4: expected LED changes and
// done pulses are queued with their cycle number, a monitor compares what it sees.
module tb_shift_sequencer;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned STEP_W   = 4;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [7:0] val;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc   = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         a;
    ev_t        sb[$];
    logic [7:0] exp_led  = 8'h00;
    logic [7:0] prev_led = 8'h00;

    shift_seq_if #(.STEP_W(STEP_W)) bus ();

    shift_sequencer #(
        .TICK_DIV (TICK_DIV),
        .STEP_W   (STEP_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_led(input int c, input logic [7:0] v);
        if (v !== exp_led) sb.push_back('{c, 1'b0, v});
        exp_led = v;
    endfunction

    function automatic void push_done(input int c);
        sb.push_back('{c, 1'b1, 8'h00});
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%02h expected=%02h", name, act, exp);
        end
    endtask

    task automatic check_event(input bit is_done, input logic [7:0] v);
        ev_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event cyc=%0d done=%0d led=%02h expected=none", cyc, is_done, v);
        end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.is_done != is_done || (!is_done && e.val !== v)) begin
                n_err++;
                $display("FAIL event got cyc=%0d done=%0d led=%02h expected cyc=%0d done=%0d led=%02h",
                         cyc, is_done, v, e.cyc, e.is_done, e.val);
            end
        end
    endtask

    // Monitor: every LED change and every done cycle is an observed event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.led !== prev_led) check_event(1'b0, bus.led);
            if (bus.done !== 1'b0) check_event(1'b1, 8'h00);
        end
        prev_led = bus.led;
    end

    task automatic issue(input logic [7:0] d, input logic [1:0] amt, input logic dir,
                         input logic rot, input logic fill, input int steps, output int acc);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_amt   = amt;
        bus.cmd_dir   = dir;
        bus.cmd_rot   = rot;
        bus.cmd_fill  = fill;
        bus.cmd_steps = STEP_W'(steps);
        acc = cyc + 1;
        push_led(acc, d);
        if (steps == 0) push_done(acc);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL idle_timeout got=busy expected=idle");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_amt   = 2'd0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_rot   = 1'b0;
        bus.cmd_fill  = 1'b0;
        bus.cmd_steps = '0;
        bus.abort     = 1'b0;
`ifdef SHIFT_SEQ_PAUSE_EN
        bus.pause     = 1'b0;
`endif
        #1;
        check("rst_led",   bus.led,       8'h00);
        check("rst_busy",  bus.busy,      8'h00);
        check("rst_done",  bus.done,      8'h00);
        check("rst_ready", bus.cmd_ready, 8'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Rotate left by 1, three steps; a second command offered while busy is ignored.
        issue(8'h81, 2'd1, 1'b0, 1'b1, 1'b0, 3, a);
        check("t1_busy",  bus.busy,      8'h01);
        check("t1_ready", bus.cmd_ready, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hFF;
        bus.cmd_steps = STEP_W'(1);
        repeat (2) @(negedge clk);
        bus.cmd_valid = 1'b0;
        push_led(a + 5, 8'h03);
        push_led(a + 9, 8'h06);
        push_led(a + 13, 8'h0C);
        push_done(a + 13);
        wait_idle();

        // Shift right by 2 with fill 1.
        issue(8'h00, 2'd2, 1'b1, 1'b0, 1'b1, 2, a);
        push_led(a + 5, 8'hC0);
        push_led(a + 9, 8'hF0);
        push_done(a + 9);
        wait_idle();

        // Zero steps: straight to DONE; a command offered during DONE is ignored.
        issue(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 0, a);
        check("t3_ready_in_done", bus.cmd_ready, 8'h00);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h77;
        bus.cmd_steps = STEP_W'(3);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("t3_ready_after", bus.cmd_ready, 8'h01);
        wait_idle();

        // Abort between steps: pattern holds, no done.
        issue(8'h0F, 2'd1, 1'b0, 1'b1, 1'b0, 5, a);
        push_led(a + 5, 8'h1E);
        repeat (5) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t4_ready", bus.cmd_ready, 8'h01);
        check("t4_busy",  bus.busy,      8'h00);
        check("t4_led",   bus.led,       8'h1E);
        wait_idle();

        // Abort on the very edge of the second step: that step is not applied.
        issue(8'h01, 2'd3, 1'b0, 1'b0, 1'b0, 2, a);
        push_led(a + 5, 8'h08);
        repeat (8) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t5_led",   bus.led,       8'h08);
        check("t5_ready", bus.cmd_ready, 8'h01);
        wait_idle();

        // Abort together with cmd_valid in IDLE: accepted; amt 0 still consumes a step.
        bus.abort = 1'b1;
        issue(8'h3C, 2'd0, 1'b1, 1'b1, 1'b0, 1, a);
        bus.abort = 1'b0;
        check("t6_busy", bus.busy, 8'h01);
        push_led(a + 5, 8'h3C);
        push_done(a + 5);
        wait_idle();

        // Rotate right by 3.
        issue(8'h01, 2'd3, 1'b1, 1'b1, 1'b0, 2, a);
        push_led(a + 5, 8'h20);
        push_led(a + 9, 8'h04);
        push_done(a + 9);
        wait_idle();

        // Reset mid-run acts without a clock edge and leaves no done behind.
        issue(8'h55, 2'd1, 1'b0, 1'b0, 1'b0, 4, a);
        push_led(a + 5, 8'hAA);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t8_led",   bus.led,       8'h00);
        check("t8_busy",  bus.busy,      8'h00);
        check("t8_ready", bus.cmd_ready, 8'h01);
        check("t8_done",  bus.done,      8'h00);
        exp_led = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("t8_busy_after", bus.busy, 8'h00);
        check("t8_led_after",  bus.led,  8'h00);

`ifdef SHIFT_SEQ_PAUSE_EN
        // Pause held for 8 cycles delays every later step by exactly 8 cycles.
        issue(8'h81, 2'd1, 1'b0, 1'b1, 1'b0, 2, a);
        @(negedge clk);
        bus.pause = 1'b1;
        repeat (8) @(negedge clk);
        bus.pause = 1'b0;
        push_led(a + 13, 8'h03);
        push_led(a + 17, 8'h06);
        push_done(a + 17);
        wait_idle();
`endif

        repeat (5) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL missing_events got=%0d pending expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
